spi_slave_regs: RTL
===================

Name: spi_slave_regs

Overview:
- SPI responder: the target-side endpoint for our APB-programmed SPI controller. It decodes two-byte SPI frames into writes and reads of a local register file.
- Runs entirely on the system clock. SPI inputs are oversampled through synchronizers; no logic is clocked by sclk.
- Local logic sees each write as a one-cycle strobe and can read any register through a combinational side port.

Parameters:
- WIDTH, 8, data width of each register and of the SPI data byte (frame is fixed at 8 command bits + WIDTH data bits; WIDTH=8 only is supported).
- DEPTH, 8, number of registers in the file; valid addresses are 0..DEPTH-1.
- AW, 3, local-side address width (log2 DEPTH).

Ports:
- pclk_i  input  1  system clock.
- prst_i  input  1  reset; asynchronous, active-high.
- sclk_i  input  1  SPI clock from controller; idles high.
- mosi_i  input  1  controller-to-responder serial data.
- ssel_n_i  input  1  slave select, active-low.
- miso_o  output  1  responder-to-controller serial data.
- miso_oe_o  output  1  tri-state enable for miso at the pad.
- wr_stb_o  output  1  one-cycle pulse: register written from SPI.
- wr_addr_o  output  AW  address of the last SPI write.
- wr_data_o  output  WIDTH  data of the last SPI write.
- frame_done_o  output  1  one-cycle pulse: a full 16-bit frame completed.
- loc_addr_i  input  AW  local read address.
- loc_rdata_o  output  WIDTH  combinational read of register[loc_addr_i].

Behaviour:
- Reset: all registers 0; miso_o=0, miso_oe_o=0, wr_stb_o=0, wr_addr_o=0, wr_data_o=0, frame_done_o=0; state IDLE; all shifters and counters 0.
- Synchronizers: 2-flop sync on sclk_i, mosi_i and ssel_n_i. Synchronizer flops reset to sclk=1, mosi=1, ssel_n=1.
- Edge detection: a 3rd flop on synced sclk gives rise (0->1) and fall (1->0) one-cycle pulses.
- Timing requirement on the controller: sclk high and sclk low each ≥4 pclk_i cycles.
- Mode 3 framing (CPOL=1, CPHA=1):
  - mosi is sampled on rise; miso changes on fall.
  - Frame is MSB first: command byte, then data byte.
  - Command bit7: 1=write, 0=read. Bits[6:0] = address.
- Selected: miso_oe_o = NOT synced ssel_n. When deselected, miso_oe_o=0 and miso_o=0.
- States and transitions:
  - IDLE: on synced ssel_n falling to 0, clear bit counter and enter CMD.
  - CMD: shift in 8 bits on rises.
    - On the 8th rise, latch the command.
    - Load tx shifter with register[addr] if addr<DEPTH, else 0x00.
    - Enter DATA.
  - DATA: shift in 8 bits on rises.
    - On each fall, miso_o <= tx[7], then tx shifts left. The first DATA fall therefore drives read bit7 before the 9th rise.
    - On the 8th DATA rise: enter DONE and pulse frame_done_o the next cycle.
    - If write and addr<DEPTH: commit register[addr] and pulse wr_stb_o in the same cycle as frame_done_o, with wr_addr_o/wr_data_o updated (those two hold until the next write).
    - Write with addr≥DEPTH: no commit, no wr_stb_o; frame_done_o still pulses.
    - Read frame: the received data byte is discarded.
  - DONE: ignore all further sclk edges; on ssel_n=1 return to IDLE.
- Abort: ssel_n rising in CMD or DATA returns to IDLE. No commit, no wr_stb_o, no frame_done_o; counters cleared.
- Back-to-back frames need ssel_n high for ≥3 pclk cycles between them.
- Reset mid-frame: immediate return to reset values. A frame in progress is lost and the register file is cleared.
- loc_rdata_o reflects a same-cycle commit only from the following cycle.

Test Plan:
- Reset, then loc_addr_i=0..7 -> loc_rdata_o=0x00 for all; miso_oe_o=0; no strobes.
- Write frame 0x83, 0xA5 (sclk half-period 4 pclk) -> one wr_stb_o pulse with wr_addr_o=3, wr_data_o=0xA5, coincident with frame_done_o; loc_addr_i=3 then gives 0xA5.
- After the previous write, read frame 0x03, 0x00 -> bits 1,0,1,0,0,1,0,1 (0xA5) sampled by the bench on rises 9..16; no wr_stb_o.
- Write 0x8A, 0x55 (addr 10 ≥ DEPTH) -> frame_done_o pulses, no wr_stb_o, registers unchanged; read 0x0A -> returns 0x00.
- Write 0x81, then ssel_n released after 4 data bits -> no strobe, register 1 unchanged; next full write 0x81, 0x3C -> register 1=0x3C.
- 20 sclk cycles within one select on a write 0x82, 0x11 -> exactly one commit of 0x11 to register 2; extra clocks ignored. Assert prst_i mid-frame -> all outputs and registers return to 0.

Source files
------------

// File: rtl/spi_slave_regs.sv
// SPI mode-3 responder decoding {cmd, data} frames into a local register file.
// All logic runs on pclk_i; SPI pins are oversampled through 2-flop synchronizers.
module spi_slave_regs #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 8,
    parameter int unsigned AW    = 3
) (
    input  logic             pclk_i,
    input  logic             prst_i,
    input  logic             sclk_i,
    input  logic             mosi_i,
    input  logic             ssel_n_i,
    output logic             miso_o,
    output logic             miso_oe_o,
    output logic             wr_stb_o,
    output logic [AW-1:0]    wr_addr_o,
    output logic [WIDTH-1:0] wr_data_o,
    output logic             frame_done_o,
    input  logic [AW-1:0]    loc_addr_i,
    output logic [WIDTH-1:0] loc_rdata_o
);

    typedef enum logic [1:0] {IDLE, CMD, DATA, DONE} state_t;

    state_t           state, state_nxt;
    logic             sclk_s1, sclk_s2, sclk_d;
    logic             mosi_s1, mosi_s2;
    logic             ssel_s1, ssel_s2;
    logic             rise, fall;
    logic [2:0]       cnt;
    logic [WIDTH-1:0] rx, tx, cmd;
    logic             miso_q;
    logic [WIDTH-1:0] regs [DEPTH];

    logic [WIDTH-1:0] rx_nxt;
    logic [WIDTH-1:0] tx_load;
    logic             cmd_end, data_end, commit;

    always_ff @(posedge pclk_i or posedge prst_i) begin
        if (prst_i) begin
            sclk_s1 <= 1'b1;
            sclk_s2 <= 1'b1;
            sclk_d  <= 1'b1;
            mosi_s1 <= 1'b1;
            mosi_s2 <= 1'b1;
            ssel_s1 <= 1'b1;
            ssel_s2 <= 1'b1;
        end else begin
            sclk_s1 <= sclk_i;
            sclk_s2 <= sclk_s1;
            sclk_d  <= sclk_s2;
            mosi_s1 <= mosi_i;
            mosi_s2 <= mosi_s1;
            ssel_s1 <= ssel_n_i;
            ssel_s2 <= ssel_s1;
        end
    end

    assign rise = sclk_s2 & ~sclk_d;
    assign fall = ~sclk_s2 & sclk_d;

    always_ff @(posedge pclk_i or posedge prst_i) begin
        if (prst_i) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (!ssel_s2) state_nxt = CMD;
            CMD: begin
                if (ssel_s2)      state_nxt = IDLE;
                else if (cmd_end) state_nxt = DATA;
            end
            DATA: begin
                if (ssel_s2)       state_nxt = IDLE;
                else if (data_end) state_nxt = DONE;
            end
            DONE: if (ssel_s2) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // An abort (ssel_n high) takes priority over a coincident sclk rise.
    always_comb begin
        rx_nxt   = {rx[WIDTH-2:0], mosi_s2};
        cmd_end  = (state == CMD)  && !ssel_s2 && rise && (cnt == 3'd7);
        data_end = (state == DATA) && !ssel_s2 && rise && (cnt == 3'd7);
        commit   = data_end && cmd[WIDTH-1] && (32'(cmd[WIDTH-2:0]) < DEPTH);
        tx_load  = '0;
        if (32'(rx_nxt[WIDTH-2:0]) < DEPTH)
            tx_load = regs[rx_nxt[AW-1:0]];
    end

    always_ff @(posedge pclk_i or posedge prst_i) begin
        if (prst_i) begin
            cnt          <= '0;
            rx           <= '0;
            tx           <= '0;
            cmd          <= '0;
            miso_q       <= 1'b0;
            wr_stb_o     <= 1'b0;
            wr_addr_o    <= '0;
            wr_data_o    <= '0;
            frame_done_o <= 1'b0;
            for (int unsigned i = 0; i < DEPTH; i++)
                regs[AW'(i)] <= '0;
        end else begin
            frame_done_o <= data_end;
            wr_stb_o     <= commit;
            if (commit) begin
                regs[cmd[AW-1:0]] <= rx_nxt;
                wr_addr_o         <= cmd[AW-1:0];
                wr_data_o         <= rx_nxt;
            end
            if (ssel_s2 || state == IDLE) begin
                cnt    <= '0;
                rx     <= '0;
                tx     <= '0;
                miso_q <= 1'b0;
            end else if (state == CMD || state == DATA) begin
                if (rise) begin
                    rx  <= rx_nxt;
                    cnt <= cnt + 3'd1;
                end
                if (cmd_end) begin
                    cmd <= rx_nxt;
                    tx  <= tx_load;
                end
                if (fall && state == DATA) begin
                    miso_q <= tx[WIDTH-1];
                    tx     <= {tx[WIDTH-2:0], 1'b0};
                end
            end
        end
    end

    assign miso_oe_o   = ~ssel_s2;
    assign miso_o      = miso_q & ~ssel_s2;
    assign loc_rdata_o = (32'(loc_addr_i) < DEPTH) ? regs[loc_addr_i] : '0;

endmodule
